// File: rtl/xdbladd_seq_pkg.sv
// Shared CSIDH definitions for the xDBLADD sequencer: default width, unit opcodes,
// FSM states, register-file indices and the instruction word format.
package xdbladd_seq_pkg;

  localparam int unsigned N_DEFAULT = 512;
  localparam int unsigned PROG_LEN  = 24;
  localparam int unsigned NREG      = 17;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  // Latched inputs first, then constants a (A24) / c (C24), temporaries and results.
  typedef enum logic [4:0] {
    R_PX, R_PZ, R_QX, R_QZ, R_PQX, R_PQZ, R_AX, R_AZ,
    R_A24, R_C24, R_T0, R_T1, R_T2,
    R_RX, R_RZ, R_SX, R_SZ
  } reg_e;

  typedef struct packed {
    reg_e       src_a;
    reg_e       src_b;
    logic [1:0] op;
    reg_e       dst;
  } instr_t;

  function automatic instr_t mk_instr(reg_e a, reg_e b, logic [1:0] op, reg_e d);
    instr_t i;
    i.src_a = a;
    i.src_b = b;
    i.op    = op;
    i.dst   = d;
    return i;
  endfunction

endpackage

// File: rtl/xdbladd_seq_rom.sv
// Combinational program table: pc -> (srcA, srcB, op, dst) for the 24-op
// curve-constant prep plus Montgomery ladder step.
module xdbladd_rom
  import xdbladd_seq_pkg::*;
(
  input  logic [4:0] pc,
  output instr_t     instr
);

  always_comb begin
    instr = mk_instr(R_PX, R_PX, OP_MUL, R_T0);
    case (pc)
      5'd0:  instr = mk_instr(R_AX,  R_AZ,  OP_ADD, R_A24);
      5'd1:  instr = mk_instr(R_A24, R_AZ,  OP_ADD, R_A24);
      5'd2:  instr = mk_instr(R_AZ,  R_AZ,  OP_ADD, R_C24);
      5'd3:  instr = mk_instr(R_C24, R_C24, OP_ADD, R_C24);
      5'd4:  instr = mk_instr(R_PX,  R_PZ,  OP_ADD, R_T0);
      5'd5:  instr = mk_instr(R_PX,  R_PZ,  OP_SUB, R_T1);
      5'd6:  instr = mk_instr(R_T0,  R_T0,  OP_MUL, R_RX);
      5'd7:  instr = mk_instr(R_QX,  R_QZ,  OP_SUB, R_T2);
      5'd8:  instr = mk_instr(R_QX,  R_QZ,  OP_ADD, R_SX);
      5'd9:  instr = mk_instr(R_T0,  R_T2,  OP_MUL, R_T0);
      5'd10: instr = mk_instr(R_T1,  R_T1,  OP_MUL, R_RZ);
      5'd11: instr = mk_instr(R_T1,  R_SX,  OP_MUL, R_T1);
      5'd12: instr = mk_instr(R_RX,  R_RZ,  OP_SUB, R_T2);
      5'd13: instr = mk_instr(R_RZ,  R_C24, OP_MUL, R_RZ);
      5'd14: instr = mk_instr(R_RX,  R_RZ,  OP_MUL, R_RX);
      5'd15: instr = mk_instr(R_A24, R_T2,  OP_MUL, R_SX);
      5'd16: instr = mk_instr(R_T0,  R_T1,  OP_SUB, R_SZ);
      5'd17: instr = mk_instr(R_RZ,  R_SX,  OP_ADD, R_RZ);
      5'd18: instr = mk_instr(R_T0,  R_T1,  OP_ADD, R_SX);
      5'd19: instr = mk_instr(R_RZ,  R_T2,  OP_MUL, R_RZ);
      5'd20: instr = mk_instr(R_SZ,  R_SZ,  OP_MUL, R_SZ);
      5'd21: instr = mk_instr(R_SX,  R_SX,  OP_MUL, R_SX);
      5'd22: instr = mk_instr(R_PQX, R_SZ,  OP_MUL, R_SZ);
      5'd23: instr = mk_instr(R_PQZ, R_SX,  OP_MUL, R_SX);
      default: ;
    endcase
  end

endmodule

// File: rtl/xdbladd_seq.sv
// xDBLADD sequencer: drives a shared mod-p unit through a fixed program,
// producing R = 2P and S = P+Q. Holds no arithmetic of its own.
module xdbladd_seq
  import xdbladd_seq_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  output logic         done,
  input  logic [N-1:0] Px,
  input  logic [N-1:0] Pz,
  input  logic [N-1:0] Qx,
  input  logic [N-1:0] Qz,
  input  logic [N-1:0] PQx,
  input  logic [N-1:0] PQz,
  input  logic [N-1:0] Ax,
  input  logic [N-1:0] Az,
  output logic [N-1:0] Rx,
  output logic [N-1:0] Rz,
  output logic [N-1:0] Sx,
  output logic [N-1:0] Sz,
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  output logic [1:0]   op,
  output logic         rst_mul,
  input  logic [N-1:0] mul,
  input  logic         done_mul
);

  state_e       state_q, state_d;
  logic [4:0]   pc_q, pc_d;
  logic         done_q, done_d;
  logic         rst_mul_q, rst_mul_d;
  logic [1:0]   op_q, op_d;
  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic [N-1:0] regs_q [NREG];
  logic [N-1:0] regs_d [NREG];
  instr_t       instr;
  logic         op_done;

  xdbladd_rom u_rom (
    .pc    (pc_q),
    .instr (instr)
  );

  // A completion flag seen while the unit is held is stale or spurious.
  assign op_done = done_mul & ~rst_mul_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (!hold) state_d = S_ISSUE;
      S_ISSUE: state_d = hold ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (hold)         state_d = S_IDLE;
        else if (op_done) state_d = (pc_q == 5'(PROG_LEN - 1)) ? S_DONE : S_ISSUE;
      end
      S_DONE:  if (hold) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    regs_d = regs_q;
    unique case (state_q)
      S_IDLE: begin
        if (!hold) begin
          regs_d[R_PX]  = Px;
          regs_d[R_PZ]  = Pz;
          regs_d[R_QX]  = Qx;
          regs_d[R_QZ]  = Qz;
          regs_d[R_PQX] = PQx;
          regs_d[R_PQZ] = PQz;
          regs_d[R_AX]  = Ax;
          regs_d[R_AZ]  = Az;
          pc_d          = '0;
        end
      end
      S_ISSUE: begin
        if (!hold) begin
          a_d  = regs_q[instr.src_a];
          b_d  = regs_q[instr.src_b];
          op_d = instr.op;
        end
      end
      S_WAIT: begin
        if (!hold && op_done) begin
          regs_d[instr.dst] = mul;
          pc_d              = pc_q + 5'd1;
        end
      end
      default: ;
    endcase
    // The unit runs only while waiting; leaving WAIT for any reason releases it.
    rst_mul_d = (state_d != S_WAIT);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= '0;
      done_q    <= 1'b0;
      rst_mul_q <= 1'b1;
      op_q      <= OP_MUL;
      a_q       <= '0;
      b_q       <= '0;
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      pc_q      <= pc_d;
      done_q    <= done_d;
      rst_mul_q <= rst_mul_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      regs_q    <= regs_d;
    end
  end

  assign done    = done_q;
  assign rst_mul = rst_mul_q;
  assign op      = op_q;
  assign A       = a_q;
  assign B       = b_q;
  assign Rx      = regs_q[R_RX];
  assign Rz      = regs_q[R_RZ];
  assign Sx      = regs_q[R_SX];
  assign Sz      = regs_q[R_SZ];

endmodule

// File: tb/tb_xdbladd_seq.sv
// Bench for xdbladd_seq: mock mod-p unit over CSIDH-512 p, golden xDBLADD model,
// scoreboard of per-op operands and final R/S results.
module tb_xdbladd_seq;

  localparam int unsigned N = 512;
  localparam logic [N-1:0] P =
    512'h65b48e8f740f89bffc8ab0d15e3e4c4ab42d083aedc88c425afbfcc69322c9cda7aac6c567f35507516730cc1f0b4f25c2721bf457aca8351b81b90533c6c87b;
  localparam logic [1:0] T_MUL = 2'b00;
  localparam logic [1:0] T_ADD = 2'b01;
  localparam logic [1:0] T_SUB = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic hold = 1'b1;
  logic done, rst_mul, done_mul;
  logic [N-1:0] Px = '0, Pz = '0, Qx = '0, Qz = '0, PQx = '0, PQz = '0, Ax = '0, Az = '0;
  logic [N-1:0] Rx, Rz, Sx, Sz, A, B;
  logic [N-1:0] mul = '0;
  logic [1:0]   op;

  always #5 clk = ~clk;

  xdbladd_seq #(.N(N)) dut (
    .clk(clk), .rst(rst), .hold(hold), .done(done),
    .Px(Px), .Pz(Pz), .Qx(Qx), .Qz(Qz), .PQx(PQx), .PQz(PQz), .Ax(Ax), .Az(Az),
    .Rx(Rx), .Rz(Rz), .Sx(Sx), .Sz(Sz), .A(A), .B(B), .op(op),
    .rst_mul(rst_mul), .mul(mul), .done_mul(done_mul)
  );

  typedef struct { logic [N-1:0] a; logic [N-1:0] b; logic [1:0] o; } op_t;
  typedef struct { logic [N-1:0] rx; logic [N-1:0] rz; logic [N-1:0] sx; logic [N-1:0] sz; } res_t;

  op_t  exp_ops[$];
  res_t exp_res[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   falls = 0;
  int   lat_sum = 0;
  bit   rand_lat = 1'b0;
  bit   spur_en = 1'b0;
  logic mock_done = 1'b0;
  logic spur_q = 1'b0;
  bit   busy = 1'b0;
  int   cnt = 0;
  int   lat = 3;

  function automatic logic [N-1:0] fadd(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[N-1:0];
  endfunction

  function automatic logic [N-1:0] fsub(input logic [N-1:0] a, input logic [N-1:0] b);
    if (a >= b) return a - b;
    return a + (P - b);
  endfunction

  function automatic logic [N-1:0] fmul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] pr;
    pr = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    pr = pr % {{N{1'b0}}, P};
    return pr[N-1:0];
  endfunction

  function automatic logic [N-1:0] alu(input logic [N-1:0] a, input logic [N-1:0] b,
                                       input logic [1:0] o);
    case (o)
      T_MUL:   return fmul(a, b);
      T_ADD:   return fadd(a, b);
      T_SUB:   return fsub(a, b);
      default: return '0;
    endcase
  endfunction

  function automatic logic [N-1:0] rnd_fe();
    logic [N-1:0] v;
    for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
    return v % P;
  endfunction

  // Mock unit: latches operands when released, reports after lat cycles;
  // optionally raises bogus done_mul pulses while held.
  assign done_mul = mock_done | (rst_mul & spur_q);

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      busy = 1'b0;
      mock_done = 1'b0;
      spur_q = 1'b0;
    end else begin
      spur_q = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rst_mul) begin
        busy = 1'b0;
        mock_done = 1'b0;
      end else if (!busy) begin
        op_t e;
        busy = 1'b1;
        cnt = 0;
        lat = rand_lat ? int'($urandom_range(1, 20)) : 3;
        lat_sum += lat;
        falls++;
        mul = alu(A, B, op);
        n_checks++;
        if (exp_ops.size() == 0) begin
          $display("FAIL op_trace #%0d: unexpected op A=%h B=%h op=%0d, none required",
                   falls - 1, A[63:0], B[63:0], op);
        end else begin
          e = exp_ops.pop_front();
          if (A !== e.a || B !== e.b || op !== e.o)
            $display("FAIL op_trace #%0d: got A=%h B=%h op=%0d want A=%h B=%h op=%0d (low 64b)",
                     falls - 1, A[63:0], B[63:0], op, e.a[63:0], e.b[63:0], e.o);
          else n_pass++;
        end
      end else begin
        cnt++;
        if (cnt >= lat) mock_done = 1'b1;
      end
    end
  end

  task automatic gold_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] o,
                         output logic [N-1:0] r);
    op_t e;
    e.a = a;
    e.b = b;
    e.o = o;
    exp_ops.push_back(e);
    r = alu(a, b, o);
  endtask

  // Straight transcription of the xDBLADD program over the current inputs.
  task automatic start_run();
    logic [N-1:0] a, c, t0, t1, t2, rx, rz, sx, sz;
    res_t r;
    gold_op(Ax, Az, T_ADD, a);   gold_op(a, Az, T_ADD, a);
    gold_op(Az, Az, T_ADD, c);   gold_op(c, c, T_ADD, c);
    gold_op(Px, Pz, T_ADD, t0);  gold_op(Px, Pz, T_SUB, t1);
    gold_op(t0, t0, T_MUL, rx);  gold_op(Qx, Qz, T_SUB, t2);
    gold_op(Qx, Qz, T_ADD, sx);  gold_op(t0, t2, T_MUL, t0);
    gold_op(t1, t1, T_MUL, rz);  gold_op(t1, sx, T_MUL, t1);
    gold_op(rx, rz, T_SUB, t2);  gold_op(rz, c, T_MUL, rz);
    gold_op(rx, rz, T_MUL, rx);  gold_op(a, t2, T_MUL, sx);
    gold_op(t0, t1, T_SUB, sz);  gold_op(rz, sx, T_ADD, rz);
    gold_op(t0, t1, T_ADD, sx);  gold_op(rz, t2, T_MUL, rz);
    gold_op(sz, sz, T_MUL, sz);  gold_op(sx, sx, T_MUL, sx);
    gold_op(PQx, sz, T_MUL, sz); gold_op(PQz, sx, T_MUL, sx);
    r.rx = rx; r.rz = rz; r.sx = sx; r.sz = sz;
    exp_res.push_back(r);
  endtask

  task automatic launch();
    @(posedge clk); #1;
    falls = 0;
    lat_sum = 0;
    @(negedge clk);
    hold = 1'b0;
  endtask

  task automatic rand_inputs();
    Px = rnd_fe(); Pz = rnd_fe(); Qx = rnd_fe(); Qz = rnd_fe();
    PQx = rnd_fe(); PQz = rnd_fe(); Ax = rnd_fe(); Az = rnd_fe();
  endtask

  // Launches a run, waits for done, scores results, then releases with hold.
  task automatic run_and_check(input string name);
    int   cycles;
    res_t r;
    start_run();
    launch();
    cycles = 0;
    while (cycles < 5000) begin
      @(posedge clk); #1;
      cycles++;
      if (done === 1'b1) break;
    end
    n_checks++;
    if (done !== 1'b1) $display("FAIL %s_done: got done=%b after %0d cycles want 1", name, done, cycles);
    else n_pass++;
    n_checks++;
    if (cycles != lat_sum + 2 * 24 + 1)
      $display("FAIL %s_latency: got %0d want %0d", name, cycles, lat_sum + 49);
    else n_pass++;
    n_checks++;
    if (falls != 24) $display("FAIL %s_op_count: got %0d want 24", name, falls);
    else n_pass++;
    n_checks++;
    if (exp_res.size() == 0) begin
      $display("FAIL %s_result: got no scoreboard entry want 1", name);
    end else begin
      r = exp_res.pop_front();
      if (Rx !== r.rx || Rz !== r.rz || Sx !== r.sx || Sz !== r.sz)
        $display("FAIL %s_result: got Rx=%h Rz=%h Sx=%h Sz=%h want Rx=%h Rz=%h Sx=%h Sz=%h (low 64b)",
                 name, Rx[63:0], Rz[63:0], Sx[63:0], Sz[63:0],
                 r.rx[63:0], r.rz[63:0], r.sx[63:0], r.sz[63:0]);
      else n_pass++;
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b1 || rst_mul !== 1'b1)
      $display("FAIL %s_done_held: got done=%b rst_mul=%b want 1 1", name, done, rst_mul);
    else n_pass++;
    @(negedge clk);
    hold = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || rst_mul !== 1'b1 || Rx !== r.rx || Sz !== r.sz)
      $display("FAIL %s_release: got done=%b rst_mul=%b Rx=%h want 0 1 %h", name, done, rst_mul,
               Rx[63:0], r.rx[63:0]);
    else n_pass++;
    exp_ops.delete();
  endtask

  task automatic check_reset_values(input string name);
    n_checks++;
    if (done !== 1'b0 || rst_mul !== 1'b1 || op !== 2'b00)
      $display("FAIL %s_ctrl: got done=%b rst_mul=%b op=%0d want 0 1 0", name, done, rst_mul, op);
    else n_pass++;
    n_checks++;
    if (A !== '0 || B !== '0 || Rx !== '0 || Rz !== '0 || Sx !== '0 || Sz !== '0)
      $display("FAIL %s_data: got A=%h B=%h Rx=%h Rz=%h Sx=%h Sz=%h want all 0 (low 64b)", name,
               A[63:0], B[63:0], Rx[63:0], Rz[63:0], Sx[63:0], Sz[63:0]);
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset_idle");
  endtask

  task automatic test_infinity();
    logic [N-1:0] four;
    four = 512'd4;
    Px = 512'd1; Pz = '0; Qx = 512'd1; Qz = '0; PQx = 512'd1; PQz = '0; Ax = '0; Az = 512'd1;
    run_and_check("infinity");
    n_checks++;
    if (Rx !== four || Rz !== '0)
      $display("FAIL infinity_const: got Rx=%h Rz=%h want 4 0", Rx[63:0], Rz[63:0]);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      run_and_check("random");
    end
  endtask

  task automatic test_random_latency();
    rand_lat = 1'b1;
    spur_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_inputs();
      run_and_check("rand_lat");
    end
    rand_lat = 1'b0;
    spur_en = 1'b0;
  endtask

  task automatic test_hold_abort();
    int guard;
    logic [N-1:0] rx0, rz0, sx0, sz0;
    rand_inputs();
    start_run();
    launch();
    guard = 0;
    while (falls < 11 && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    n_checks++;
    if (falls != 11) $display("FAIL abort_reach_op10: got %0d ops want 11", falls);
    else n_pass++;
    rx0 = Rx; rz0 = Rz; sx0 = Sx; sz0 = Sz;
    @(negedge clk);
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || rst_mul !== 1'b1)
        $display("FAIL abort_idle: got done=%b rst_mul=%b want 0 1", done, rst_mul);
      else n_pass++;
    end
    n_checks++;
    if (falls != 11 || Rx !== rx0 || Rz !== rz0 || Sx !== sx0 || Sz !== sz0)
      $display("FAIL abort_frozen: got ops=%0d Rx=%h Rz=%h want 11 %h %h", falls,
               Rx[63:0], Rz[63:0], rx0[63:0], rz0[63:0]);
    else n_pass++;
    exp_ops.delete();
    exp_res.delete();
    rand_inputs();
    run_and_check("after_abort");
  endtask

  task automatic test_reset_mid_wait();
    int guard;
    rand_inputs();
    start_run();
    launch();
    guard = 0;
    while (falls < 5 && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    n_checks++;
    if (rst_mul !== 1'b0) $display("FAIL rst_mid_in_wait: got rst_mul=%b want 0", rst_mul);
    else n_pass++;
    #2;
    rst = 1'b0;
    hold = 1'b1;
    #1;
    check_reset_values("rst_mid");
    exp_ops.delete();
    exp_res.delete();
    @(negedge clk);
    rst = 1'b1;
    falls = 0;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (falls != 0 || rst_mul !== 1'b1 || done !== 1'b0)
      $display("FAIL rst_mid_no_issue: got ops=%0d rst_mul=%b done=%b want 0 1 0", falls, rst_mul, done);
    else n_pass++;
    rand_inputs();
    run_and_check("after_reset");
  endtask

  initial begin
    test_reset();
    test_infinity();
    test_random();
    test_random_latency();
    test_hold_abort();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
